// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Hazard and sequencing controller for a 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//   Generates pipeline-register stall/flush controls, the ID and EX forwarding
//   selects, drains the pipeline before a syscall is serviced, and counts
//   stall cycles.
//
// Ports
//   clk, reset                    rising-edge clock, async active-high reset
//   rs_D, rt_D                    ID source registers
//   rs_E, rt_E                    EX source registers
//   writeReg_E/_M/_W              destination registers in EX/MEM/WB
//   regWrite_E/_M/_W              register-write enables in EX/MEM/WB
//   memToReg_E, memToReg_M        load flags in EX/MEM
//   branch_D, jr_D, syscall_D     instruction class in ID
//   syscall_exit                  exit request, sampled in SERVICE
//   pcsrc_D                       taken branch / jump resolved in ID
//   stall_F, stall_D              hold PC / IF_ID
//   flush_D, flush_E              clear IF_ID / ID_EX
//   forwardA_D, forwardB_D        ID comparator operand from ALUOut_M
//   forwardA_E, forwardB_E        ALU operand select: 00 RD, 10 ALUOut_M, 01 Result_W
//   syscall_fire                  one-cycle syscall enable
//   halted                        processor halted
//   stall_count                   saturating stall-cycle counter
module hazard_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic [4:0]       rs_E,
  input  logic [4:0]       rt_E,
  input  logic [4:0]       writeReg_E,
  input  logic [4:0]       writeReg_M,
  input  logic [4:0]       writeReg_W,
  input  logic             regWrite_E,
  input  logic             regWrite_M,
  input  logic             regWrite_W,
  input  logic             memToReg_E,
  input  logic             memToReg_M,
  input  logic             branch_D,
  input  logic             jr_D,
  input  logic             syscall_D,
  input  logic             syscall_exit,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  input  logic             pcsrc_D,
  output logic             forwardA_D,
  output logic             forwardB_D,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             syscall_fire,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SERVICE, S_HALT} state_t;

  state_t           r_state, w_state_nxt;
  logic [DW-1:0]    r_drain, w_drain_nxt;
  logic             r_sys_flush, w_sys_flush_nxt;
  logic [CNT_W-1:0] r_stall_count;

  logic w_m_rsE, w_w_rsE, w_m_rtE, w_w_rtE;
  logic w_e_rsD, w_e_rtD, w_ml_rsD, w_ml_rtD;
  logic w_lwstall, w_brstall, w_hazard;

  // Register matches; register 0 never matches.
  always_comb begin
    w_m_rsE  = regWrite_M && (writeReg_M != '0) && (writeReg_M == rs_E);
    w_m_rtE  = regWrite_M && (writeReg_M != '0) && (writeReg_M == rt_E);
    w_w_rsE  = regWrite_W && (writeReg_W != '0) && (writeReg_W == rs_E);
    w_w_rtE  = regWrite_W && (writeReg_W != '0) && (writeReg_W == rt_E);
    w_e_rsD  = (writeReg_E != '0) && (writeReg_E == rs_D);
    w_e_rtD  = (writeReg_E != '0) && (writeReg_E == rt_D);
    w_ml_rsD = memToReg_M && (writeReg_M != '0) && (writeReg_M == rs_D);
    w_ml_rtD = memToReg_M && (writeReg_M != '0) && (writeReg_M == rt_D);
  end

  always_comb begin
    forwardA_E = w_m_rsE ? 2'b10 : (w_w_rsE ? 2'b01 : 2'b00);
    forwardB_E = w_m_rtE ? 2'b10 : (w_w_rtE ? 2'b01 : 2'b00);
    forwardA_D = regWrite_M && (writeReg_M != '0) && (writeReg_M == rs_D);
    forwardB_D = regWrite_M && (writeReg_M != '0) && (writeReg_M == rt_D);
  end

  // jr only reads rs, so rt hazards apply to branches alone.
  always_comb begin
    w_lwstall = memToReg_E && (w_e_rsD || w_e_rtD);
    w_brstall = (branch_D || jr_D) &&
                ((regWrite_E && (w_e_rsD || (branch_D && w_e_rtD))) ||
                 (w_ml_rsD || (branch_D && w_ml_rtD)));
    w_hazard  = w_lwstall || w_brstall;
  end

  // Next state and outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_nxt     = r_drain;
    w_sys_flush_nxt = 1'b0;
    stall_F         = 1'b0;
    stall_D         = 1'b0;
    flush_E         = 1'b0;
    syscall_fire    = 1'b0;
    halted          = 1'b0;
    unique case (r_state)
      S_RUN: begin
        stall_F = w_hazard;
        stall_D = w_hazard;
        flush_E = w_hazard;
        // The cycle after service the syscall is still in ID being flushed;
        // it must not start a second drain.
        if (syscall_D && !w_hazard && !r_sys_flush) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = DW'(DRAIN_CYCLES - 1);
        end
      end
      S_DRAIN: begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
        if (r_drain == '0) w_state_nxt = S_SERVICE;
        else               w_drain_nxt = r_drain - 1'b1;
      end
      S_SERVICE: begin
        stall_F      = 1'b1;
        stall_D      = 1'b1;
        flush_E      = 1'b1;
        syscall_fire = 1'b1;
        if (syscall_exit) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt     = S_RUN;
          w_sys_flush_nxt = 1'b1;
        end
      end
      S_HALT: begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
        halted  = 1'b1;
      end
      default: w_state_nxt = S_RUN;
    endcase
    flush_D = r_sys_flush || (pcsrc_D && !stall_D);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_drain     <= '0;
      r_sys_flush <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain     <= w_drain_nxt;
      r_sys_flush <= w_sys_flush_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (stall_D && (r_state != S_HALT) && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  localparam int DRAIN = 3;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int NCYC  = 4000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    rs_D = '0, rt_D = '0, rs_E = '0, rt_E = '0;
  logic [4:0]    writeReg_E = '0, writeReg_M = '0, writeReg_W = '0;
  logic          regWrite_E = 0, regWrite_M = 0, regWrite_W = 0;
  logic          memToReg_E = 0, memToReg_M = 0;
  logic          branch_D = 0, jr_D = 0, syscall_D = 0, syscall_exit = 0, pcsrc_D = 0;
  logic          stall_F, stall_D, flush_D, flush_E, forwardA_D, forwardB_D;
  logic [1:0]    forwardA_E, forwardB_E;
  logic          syscall_fire, halted;
  logic [CW-1:0] stall_count;

  hazard_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
    .writeReg_E(writeReg_E), .writeReg_M(writeReg_M), .writeReg_W(writeReg_W),
    .regWrite_E(regWrite_E), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
    .memToReg_E(memToReg_E), .memToReg_M(memToReg_M),
    .branch_D(branch_D), .jr_D(jr_D), .syscall_D(syscall_D), .syscall_exit(syscall_exit),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .pcsrc_D(pcsrc_D), .forwardA_D(forwardA_D), .forwardB_D(forwardB_D),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .syscall_fire(syscall_fire), .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sF, sD, fD, fE, faD, fbD, fire, hlt;
    logic [1:0] faE, fbE;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: pipeline mode as plain counters/flags.
  int m_drain_left;   // -1 when not draining
  bit m_service, m_halt, m_sysflush;
  int m_cnt;

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] src);
    if (regWrite_M && hit(writeReg_M, src)) return 2'b10;
    if (regWrite_W && hit(writeReg_W, src)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare at negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall_F",      int'(stall_F),      int'(e.sF));
      check("stall_D",      int'(stall_D),      int'(e.sD));
      check("flush_D",      int'(flush_D),      int'(e.fD));
      check("flush_E",      int'(flush_E),      int'(e.fE));
      check("forwardA_D",   int'(forwardA_D),   int'(e.faD));
      check("forwardB_D",   int'(forwardB_D),   int'(e.fbD));
      check("forwardA_E",   int'(forwardA_E),   int'(e.faE));
      check("forwardB_E",   int'(forwardB_E),   int'(e.fbE));
      check("syscall_fire", int'(syscall_fire), int'(e.fire));
      check("halted",       int'(halted),       int'(e.hlt));
      check("stall_count",  int'(stall_count),  e.cnt);
    end
  end

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 3));
  endfunction

  initial begin
    exp_t e;
    bit   lw, br, busy, stall;
    m_drain_left = -1; m_service = 0; m_halt = 0; m_sysflush = 0; m_cnt = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc < 2) begin
        reset = 1'b1;
      end else begin
        // Stay halted for a while so frozen behaviour is observed.
        reset = m_halt ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 299) == 0);
        rs_D = rreg(); rt_D = rreg(); rs_E = rreg(); rt_E = rreg();
        writeReg_E = rreg(); writeReg_M = rreg(); writeReg_W = rreg();
        regWrite_E = 1'($urandom); regWrite_M = 1'($urandom); regWrite_W = 1'($urandom);
        memToReg_E = ($urandom_range(0, 3) == 0);
        memToReg_M = ($urandom_range(0, 3) == 0);
        branch_D   = ($urandom_range(0, 3) == 0);
        jr_D       = ($urandom_range(0, 5) == 0);
        syscall_D  = ($urandom_range(0, 4) == 0);
        syscall_exit = ($urandom_range(0, 3) == 0);
        pcsrc_D    = ($urandom_range(0, 3) == 0);
      end
      if (reset) begin
        m_drain_left = -1; m_service = 0; m_halt = 0; m_sysflush = 0; m_cnt = 0;
      end
      lw = memToReg_E && (hit(writeReg_E, rs_D) || hit(writeReg_E, rt_D));
      br = (branch_D || jr_D) &&
           ((regWrite_E && (hit(writeReg_E, rs_D) || (branch_D && hit(writeReg_E, rt_D)))) ||
            (memToReg_M && (hit(writeReg_M, rs_D) || (branch_D && hit(writeReg_M, rt_D)))));
      busy  = (m_drain_left >= 0) || m_service || m_halt;
      stall = busy || lw || br;
      e.sF = stall; e.sD = stall; e.fE = stall;
      e.fD = (!busy && m_sysflush) || (pcsrc_D && !stall);
      e.faD = regWrite_M && hit(writeReg_M, rs_D);
      e.fbD = regWrite_M && hit(writeReg_M, rt_D);
      e.faE = fwd(rs_E);
      e.fbE = fwd(rt_E);
      e.fire = m_service;
      e.hlt  = m_halt;
      e.cnt  = m_cnt;
      exp_q.push_back(e);
      // Effect of the coming clock edge.
      if (!reset) begin
        if (stall && !m_halt && m_cnt < CMAX) m_cnt++;
        if (m_halt) begin
          // only reset leaves
        end else if (m_service) begin
          m_service = 0;
          if (syscall_exit) m_halt = 1;
          else              m_sysflush = 1;
        end else if (m_drain_left >= 0) begin
          if (m_drain_left == 0) begin
            m_drain_left = -1;
            m_service = 1;
          end else begin
            m_drain_left--;
          end
        end else begin
          if (syscall_D && !lw && !br && !m_sysflush) m_drain_left = DRAIN - 1;
          m_sysflush = 0;
        end
      end
    end
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
